// File: rtl/stage_ma.sv
// -----------------------------------------------------------------------------
// stage_ma_pkg + stage_ma
//
// Memory-access stage of the 5-stage RV32 pipeline. Takes the EX-MA pipeline
// register and runs loads/stores on a valid/ready data-memory port. While a
// transaction is outstanding, the stage holds the upstream pipeline. It aligns
// store data and byte enables to the addressed lanes, and extends load data.
// The result is registered into the MA-WB pipeline register.
//
// Ports:
//   clk, rst_ni          clock, asynchronous active-low reset
//   ex_ma_i              EX-MA pipeline register
//   stall_i              hazard-unit stall; holds ma_wb_reg_o
//   stall_o              MA busy, upstream must hold
//   dmem_req_valid_o     request valid  / dmem_req_ready_i  request accepted
//   dmem_addr_o          word-aligned address
//   dmem_we_o            1 = store
//   dmem_be_o            byte enables
//   dmem_wdata_o         lane-replicated store data
//   dmem_rvalid_i        load data valid / dmem_rdata_i  load data
//   misalign_o           one-cycle misaligned-access pulse
//   ma_wb_reg_o          MA-WB pipeline register
//
// Optional feature: define MA_MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses. A trapped access issues no request and pulses misalign_o, and
// it is retired with reg_wr_en cleared. Without the macro, misalign_o is tied
// to 0 and the unused low address bits are ignored.
// -----------------------------------------------------------------------------
package stage_ma_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic [31:0] dmem_data;
        logic        dmem_rd_en;
        logic        dmem_wr_en;
        logic [1:0]  dmem_size;
        logic        dmem_sign;
        logic        reg_wr_en;
        logic [1:0]  reg_wr_sel;
        logic [4:0]  reg_wr_addr;
    } ex_ma_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic        reg_wr_en;
        logic [1:0]  reg_wr_sel;
        logic [4:0]  reg_wr_addr;
    } ma_wb_reg_t;

endpackage

module stage_ma
    import stage_ma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  ex_ma_reg_t  ex_ma_i,
    input  logic        stall_i,
    output logic        stall_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        misalign_o,
    output ma_wb_reg_t  ma_wb_reg_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    ma_wb_reg_t  ma_wb_q, ma_wb_d;
    ma_wb_reg_t  buf_q, buf_d;      // completed result parked while stall_i holds
    logic [29:0] addr_q, addr_d;
    logic [1:0]  lo_q, lo_d;        // low address bits, for load lane select
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;

    logic        mem_op;
    logic        trap;
    logic        complete;
    ma_wb_reg_t  result;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    // dmem_sign=0 sign-extends, dmem_sign=1 zero-extends.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  lo,
                                                 input logic [1:0]  size,
                                                 input logic        zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return zext ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return zext ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        mem_op = ex_ma_i.valid && (ex_ma_i.dmem_rd_en || ex_ma_i.dmem_wr_en);
`ifdef MA_MISALIGN_TRAP_EN
        trap = mem_op &&
               (((ex_ma_i.dmem_size == 2'b01) && ex_ma_i.alu_result[0]) ||
                (ex_ma_i.dmem_size[1] && (ex_ma_i.alu_result[1:0] != 2'b00)));
`else
        trap = 1'b0;
`endif
        misalign_o = (state_q == S_IDLE) && trap;
    end

    // Store lane placement for the instruction currently in EX-MA.
    always_comb begin
        case (ex_ma_i.dmem_size)
            2'b00: begin
                be_new    = 4'b0001 << ex_ma_i.alu_result[1:0];
                wdata_new = {4{ex_ma_i.dmem_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ex_ma_i.alu_result[1], 1'b0};
                wdata_new = {2{ex_ma_i.dmem_data[15:0]}};
            end
            default: begin
                be_new    = 4'hF;
                wdata_new = ex_ma_i.dmem_data;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ma_wb_d  = ma_wb_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        sign_d   = sign_q;
        complete = 1'b0;

        // EX-MA is held by stall_o during a transaction, so its fields are
        // still valid when the transaction completes.
        result.valid        = ex_ma_i.valid;
        result.pc_plus_four = ex_ma_i.pc_plus_four;
        result.alu_result   = ex_ma_i.alu_result;
        result.load_data    = 32'b0;
        result.reg_wr_en    = ex_ma_i.reg_wr_en;
        result.reg_wr_sel   = ex_ma_i.reg_wr_sel;
        result.reg_wr_addr  = ex_ma_i.reg_wr_addr;

        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    complete         = 1'b1;
                    result.reg_wr_en = 1'b0;
                end else if (mem_op) begin
                    addr_d  = ex_ma_i.alu_result[31:2];
                    lo_d    = ex_ma_i.alu_result[1:0];
                    we_d    = ex_ma_i.dmem_wr_en;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    size_d  = ex_ma_i.dmem_size;
                    sign_d  = ex_ma_i.dmem_sign;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    ma_wb_d = result;
                end
            end
            S_REQ: begin
                if (dmem_req_ready_i) begin
                    if (we_q) complete = 1'b1;
                    else      state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    complete         = 1'b1;
                    result.load_data = load_extract(dmem_rdata_i, lo_q, size_q, sign_q);
                end
            end
            S_DONE: begin
                if (!stall_i) begin
                    ma_wb_d = buf_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            if (stall_i) begin
                buf_d   = result;
                state_d = S_DONE;
            end else begin
                ma_wb_d = result;
                state_d = S_IDLE;
            end
        end

        stall_o = mem_op && (state_q != S_DONE) && !complete;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ma_wb_q <= '0;
        end else begin
            state_q <= state_d;
            ma_wb_q <= ma_wb_d;
        end
    end

    // Request and result buffers only matter once loaded, so they have no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        lo_q    <= lo_d;
        we_q    <= we_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        sign_q  <= sign_d;
        buf_q   <= buf_d;
    end

    assign dmem_req_valid_o = (state_q == S_REQ);
    assign dmem_addr_o      = {addr_q, 2'b00};
    assign dmem_we_o        = we_q;
    assign dmem_be_o        = be_q;
    assign dmem_wdata_o     = wdata_q;
    assign ma_wb_reg_o      = ma_wb_q;

endmodule

// File: tb/tb_stage_ma.sv
module tb_stage_ma;
    import stage_ma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    ex_ma_reg_t  ex_ma_i;
    logic        stall_i;
    logic        stall_o;
    logic        req_valid;
    logic        ready;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misalign;
    ma_wb_reg_t  ma_wb;

    int checks   = 0;
    int failures = 0;
    ma_wb_reg_t prev_wb;   // model's view of what MA-WB currently holds
    int st;

    stage_ma dut (
        .clk              (clk),
        .rst_ni           (rst_ni),
        .ex_ma_i          (ex_ma_i),
        .stall_i          (stall_i),
        .stall_o          (stall_o),
        .dmem_req_valid_o (req_valid),
        .dmem_req_ready_i (ready),
        .dmem_addr_o      (addr),
        .dmem_we_o        (we),
        .dmem_be_o        (be),
        .dmem_wdata_o     (wdata),
        .dmem_rvalid_i    (rvalid),
        .dmem_rdata_i     (rdata),
        .misalign_o       (misalign),
        .ma_wb_reg_o      (ma_wb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sgn);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return w;
    endfunction

    function automatic ex_ma_reg_t mk(input logic v, input logic rd, input logic wr,
                                      input logic [1:0] sz, input logic sg,
                                      input logic [31:0] a, input logic [31:0] d);
        ex_ma_reg_t x;
        x.valid        = v;
        x.pc_plus_four = $urandom;
        x.alu_result   = a;
        x.dmem_data    = d;
        x.dmem_rd_en   = rd;
        x.dmem_wr_en   = wr;
        x.dmem_size    = sz;
        x.dmem_sign    = sg;
        x.reg_wr_en    = !wr;
        x.reg_wr_sel   = 2'($urandom);
        x.reg_wr_addr  = 5'($urandom);
        return x;
    endfunction

    // Completion edge plus optional stall_i hold (stall_i already raised in the
    // completion cycle when stall_cyc > 0).
    task automatic finish(input ma_wb_reg_t e, input int stall_cyc);
        tick();
        ready  = 1'b0;
        rvalid = 1'b0;
        if (stall_cyc > 0) begin
            for (int s = 1; s < stall_cyc; s++) begin
                check("hold_wb", ma_wb, prev_wb);
                check("hold_stall_o", stall_o, 1'b0);
                check("hold_no_req", req_valid, 1'b0);
                check("hold_misalign", misalign, 1'b0);
                tick();
            end
            check("hold_wb_last", ma_wb, prev_wb);
            stall_i = 1'b0;
            #1;
            check("release_stall_o", stall_o, 1'b0);
            tick();
        end
        check("wb_result", ma_wb, e);
        prev_wb = e;
    endtask

    task automatic do_txn(input ex_ma_reg_t ins, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rd, input int stall_cyc, output int st_o);
        logic mem, ld, str, mis, trp;
        ma_wb_reg_t e;
        int cnt, exp_cnt;
        logic [31:0] a;
        a   = ins.alu_result;
        mem = ins.valid && (ins.dmem_rd_en || ins.dmem_wr_en);
        str = ins.dmem_wr_en;
        ld  = !str;
        mis = ((ins.dmem_size == 2'd1) && (a % 2 == 1)) ||
              ((ins.dmem_size >= 2'd2) && (a % 4 != 0));
`ifdef MA_MISALIGN_TRAP_EN
        trp = mem && mis;
`else
        trp = 1'b0;
`endif
        e.valid        = ins.valid;
        e.pc_plus_four = ins.pc_plus_four;
        e.alu_result   = a;
        e.load_data    = (mem && ld && !trp) ? m_load(rd, a, ins.dmem_size, ins.dmem_sign) : 32'h0;
        e.reg_wr_en    = ins.reg_wr_en && !trp;
        e.reg_wr_sel   = ins.reg_wr_sel;
        e.reg_wr_addr  = ins.reg_wr_addr;
        exp_cnt = (!mem || trp) ? 0 : 1 + rdy_dly + (ld ? 1 + rv_dly : 0);
        cnt = 0;

        ex_ma_i = ins;
        ready   = 1'b0;
        rvalid  = 1'($urandom % 2);   // stray rvalid in IDLE must be ignored
        rdata   = $urandom;
        stall_i = 1'b0;
        if (!mem || trp) stall_i = (stall_cyc > 0);
        #1;
        check("idle_misalign", misalign, trp);
        check("idle_no_req", req_valid, 1'b0);
        if (!mem || trp) begin
            check("idle_stall_o", stall_o, 1'b0);
        end else begin
            check("idle_stall_o", stall_o, 1'b1);
            cnt++;
            tick();
            for (int k = 0; k <= rdy_dly; k++) begin
                ready  = (k == rdy_dly);
                rvalid = 1'($urandom % 2);
                rdata  = $urandom;
                if (str && ready) stall_i = (stall_cyc > 0);
                #1;
                check("req_valid", req_valid, 1'b1);
                check("req_addr", addr, a & 32'hFFFF_FFFC);
                check("req_we", we, str);
                check("req_be", be, m_be(a, ins.dmem_size));
                check("req_wdata", wdata, m_wdata(ins.dmem_data, ins.dmem_size));
                check("req_hold_wb", ma_wb, prev_wb);
                if (str && ready) begin
                    check("req_done_stall_o", stall_o, 1'b0);
                end else begin
                    check("req_stall_o", stall_o, 1'b1);
                    cnt++;
                    tick();
                end
            end
            if (ld) begin
                ready = 1'b0;
                for (int j = 0; j <= rv_dly; j++) begin
                    rvalid = (j == rv_dly);
                    rdata  = rvalid ? rd : $urandom;
                    ready  = 1'($urandom % 2);
                    if (rvalid) stall_i = (stall_cyc > 0);
                    #1;
                    check("wait_no_req", req_valid, 1'b0);
                    check("wait_hold_wb", ma_wb, prev_wb);
                    if (rvalid) begin
                        check("wait_done_stall_o", stall_o, 1'b0);
                    end else begin
                        check("wait_stall_o", stall_o, 1'b1);
                        cnt++;
                        tick();
                    end
                end
            end
        end
        check("stall_cycles", cnt, exp_cnt);
        st_o = cnt;
        finish(e, stall_cyc);
    endtask

    initial begin
        rst_ni  = 1'b0;
        ex_ma_i = '0;
        stall_i = 1'b0;
        ready   = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        prev_wb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb", ma_wb, 105'h0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_stall_o", stall_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Non-memory instruction passes in one cycle
        do_txn(mk(1, 0, 0, 2'd2, 0, 32'h0000_1234, 32'h0), 0, 0, 32'h0, 0, st);

        // Byte load, both extension modes
        do_txn(mk(1, 1, 0, 2'd0, 0, 32'h0000_1003, 32'h0), 0, 0, 32'h80FF_0000, 0, st);
        check("byte_load_sext", ma_wb.load_data, 32'hFFFF_FF80);
        do_txn(mk(1, 1, 0, 2'd0, 1, 32'h0000_1003, 32'h0), 0, 0, 32'h80FF_0000, 0, st);
        check("byte_load_zext", ma_wb.load_data, 32'h0000_0080);

        // Half store lane placement
        do_txn(mk(1, 0, 1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD), 0, 0, 32'h0, 0, st);

        // Backpressure: ready low 3 cycles, rvalid 2 cycles after the handshake
        do_txn(mk(1, 1, 0, 2'd2, 0, 32'h0000_5008, 32'h0), 3, 1, 32'hCAFE_F00D, 0, st);
        check("bp_stall_count", st, 6);
        check("bp_load_word", ma_wb.load_data, 32'hCAFE_F00D);

        // stall_i on the completion cycle for 4 cycles
        do_txn(mk(1, 1, 0, 2'd1, 0, 32'h0000_6002, 32'h0), 1, 0, 32'h8001_7FFF, 4, st);
        do_txn(mk(1, 0, 1, 2'd0, 0, 32'h0000_6001, 32'h55AA_33CC), 2, 0, 32'h0, 3, st);
        do_txn(mk(1, 0, 0, 2'd0, 0, 32'h0000_0040, 32'h0), 0, 0, 32'h0, 2, st);

        // Misaligned word load (trapped or issued depending on build)
        do_txn(mk(1, 1, 0, 2'd2, 0, 32'h0000_3001, 32'h0), 0, 0, 32'h1122_3344, 0, st);
        do_txn(mk(1, 1, 0, 2'd2, 0, 32'h0000_3001, 32'h0), 0, 0, 32'h1122_3344, 2, st);
        do_txn(mk(1, 0, 1, 2'd1, 1, 32'h0000_3003, 32'h9876_5432), 1, 0, 32'h0, 0, st);

        // Invalid instruction with a load flagged never requests
        do_txn(mk(0, 1, 0, 2'd0, 0, 32'h0000_7000, 32'h0), 0, 0, 32'h0, 0, st);

        // Randomised mix
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic v;
            kind = int'($urandom % 3);
            v    = ($urandom % 8) != 0;
            do_txn(mk(v, kind == 1, kind == 2, 2'($urandom), 1'($urandom),
                      $urandom, $urandom),
                   int'($urandom % 4), int'($urandom % 4), $urandom,
                   (($urandom % 4) == 0) ? 1 + int'($urandom % 3) : 0, st);
        end

        // Reset in WAIT, then a late rvalid
        ex_ma_i = mk(1, 1, 0, 2'd2, 0, 32'h0000_4000, 32'h0);
        ready   = 1'b0;
        rvalid  = 1'b0;
        stall_i = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        #1;
        check("rst_mid_wait_stall_o", stall_o, 1'b1);
        rst_ni  = 1'b0;
        ex_ma_i = '0;
        rvalid  = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        #1;
        check("rst_mid_wb_cleared", ma_wb, 105'h0);
        tick();
        rst_ni = 1'b1;
        #1;
        check("rst_mid_no_req", req_valid, 1'b0);
        check("rst_mid_stall_o", stall_o, 1'b0);
        tick();
        check("rst_mid_no_update", ma_wb, 105'h0);
        check("rst_mid_valid", ma_wb.valid, 1'b0);
        rvalid  = 1'b0;
        prev_wb = '0;

        // Normal operation after reset
        do_txn(mk(1, 1, 0, 2'd1, 0, 32'h0000_8002, 32'h0), 0, 2, 32'h7FFF_0001, 0, st);
        check("post_rst_half_sext", ma_wb.load_data, 32'h0000_7FFF);

        ex_ma_i = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
